mem_wb_stage: RTL and testbench

//  MEM->WB pipeline stage. Registers the memory-stage result, selects load data or ALU

---
 rtl/mem_wb_pkg.sv | 18 +
 rtl/mem_wb_skid_buf.sv | 96 +++++++++
 rtl/mem_wb_stage.sv | 110 +++++++++++
 tb/tb_mem_wb_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the MEM->WB writeback stage.
package mem_wb_pkg;

  localparam int PKG_DATA_W = 32;
  localparam int PKG_REG_AW = 5;

  localparam logic [5:0] OPC_LW = 6'b100011;
  localparam logic [5:0] OPC_SW = 6'b101011;

  localparam int ZERO_REG = 0;

  typedef struct packed {
    logic [PKG_DATA_W-1:0] data;
    logic [PKG_REG_AW-1:0] rd;
    logic                  we;
  } wb_entry_t;

endpackage

// File: rtl/mem_wb_skid_buf.sv
// Generic 2-entry (head + skid) valid/ready buffer with a registered ready.
// FWD_BYPASS_EN exposes the skid slot so the parent can forward from it.
module mem_wb_skid_buf
  import mem_wb_pkg::*;
#(
  parameter type T = wb_entry_t
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  input  logic i_ready,
  output logic o_valid,
  output T     o_head,
  output logic o_pop
`ifdef FWD_BYPASS_EN
  ,
  output logic o_skid_valid,
  output T     o_skid
`endif
);

  logic r_head_valid;
  logic r_skid_valid;
  logic r_ready;
  T     r_head;
  T     r_skid;

  logic w_accept;
  logic w_pop;
  logic w_head_valid_next;
  logic w_skid_valid_next;
  T     w_head_next;
  T     w_skid_next;

  assign w_accept = i_valid & r_ready & ~flush;
  assign w_pop    = r_head_valid & i_ready;

  always_comb begin
    w_head_valid_next = r_head_valid;
    w_skid_valid_next = r_skid_valid;
    w_head_next       = r_head;
    w_skid_next       = r_skid;
    if (!r_head_valid) begin
      if (w_accept) begin
        w_head_valid_next = 1'b1;
        w_head_next       = i_data;
      end
    end else if (w_pop) begin
      if (r_skid_valid) begin
        w_head_next       = r_skid;
        w_skid_valid_next = w_accept;
        if (w_accept) w_skid_next = i_data;
      end else begin
        w_head_valid_next = w_accept;
        if (w_accept) w_head_next = i_data;
      end
    end else if (w_accept) begin
      w_skid_valid_next = 1'b1;
      w_skid_next       = i_data;
    end
    // Flush kills the buffered entries but leaves stale payload bits in place.
    if (flush) begin
      w_head_valid_next = 1'b0;
      w_skid_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
      r_head       <= '0;
      r_skid       <= '0;
    end else begin
      r_head_valid <= w_head_valid_next;
      r_skid_valid <= w_skid_valid_next;
      r_ready      <= ~w_skid_valid_next;
      r_head       <= w_head_next;
      r_skid       <= w_skid_next;
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_head_valid;
  assign o_head  = r_head;
  assign o_pop   = w_pop;
`ifdef FWD_BYPASS_EN
  assign o_skid_valid = r_skid_valid;
  assign o_skid       = r_skid;
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB stage: writeback mux, skid buffering, retire counter.
// Define FWD_BYPASS_EN to add the fwd_valid/fwd_rd/fwd_data forwarding outputs.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = PKG_DATA_W,
  parameter int REG_AW = PKG_REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_read,
  input  logic              reg_write,
  input  logic [REG_AW-1:0] rd,
  input  logic              wb_ready,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retire_count
`ifdef FWD_BYPASS_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] rd;
    logic              we;
  } entry_t;

  entry_t            w_in_entry;
  entry_t            w_head;
  logic              w_head_valid;
  logic              w_pop;
  logic [CNT_W-1:0]  r_retire_count;

  // Writes to the hardwired zero register are demoted to no-writes at capture.
  always_comb begin
    w_in_entry.data = mem_read ? mem_data : alu_result;
    w_in_entry.rd   = rd;
    w_in_entry.we   = reg_write & (rd != REG_AW'(ZERO_REG));
  end

`ifdef FWD_BYPASS_EN
  entry_t w_skid;
  logic   w_skid_valid;
`endif

  mem_wb_skid_buf #(
    .T (entry_t)
  ) u_skid_buf (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .i_valid      (in_valid),
    .o_ready      (in_ready),
    .i_data       (w_in_entry),
    .i_ready      (wb_ready),
    .o_valid      (w_head_valid),
    .o_head       (w_head),
    .o_pop        (w_pop)
`ifdef FWD_BYPASS_EN
    ,
    .o_skid_valid (w_skid_valid),
    .o_skid       (w_skid)
`endif
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retire_count <= '0;
    end else if (w_pop) begin
      r_retire_count <= r_retire_count + CNT_W'(1);
    end
  end

  assign wb_valid     = w_head_valid;
  assign wb_we        = w_head_valid & w_head.we;
  assign wb_rd        = w_head.rd;
  assign wb_data      = w_head.data;
  assign retire_count = r_retire_count;

`ifdef FWD_BYPASS_EN
  // The skid entry is younger than the head, so it wins when both write.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    if (w_skid_valid && w_skid.we) begin
      fwd_valid = 1'b1;
      fwd_rd    = w_skid.rd;
      fwd_data  = w_skid.data;
    end else if (w_head_valid && w_head.we) begin
      fwd_valid = 1'b1;
      fwd_rd    = w_head.rd;
      fwd_data  = w_head.data;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: queue-based reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_mem_wb_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] alu_result = '0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_read = 1'b0;
  logic          reg_write = 1'b0;
  logic [AW-1:0] rd = '0;
  logic          wb_ready = 1'b0;
  logic          wb_valid;
  logic          wb_we;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [CW-1:0] retire_count;
`ifdef FWD_BYPASS_EN
  logic          fwd_valid;
  logic [AW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_result   (alu_result),
    .mem_data     (mem_data),
    .mem_read     (mem_read),
    .reg_write    (reg_write),
    .rd           (rd),
    .wb_ready     (wb_ready),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .retire_count (retire_count)
`ifdef FWD_BYPASS_EN
    ,
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] rd;
    logic          we;
  } ent_t;

  ent_t          q[$];
  logic          m_ready = 1'b1;
  logic [CW-1:0] m_count = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of depth 2 whose ready reflects occupancy.
  always @(posedge clk or negedge reset) begin : model
    bit   acc;
    bit   pop;
    ent_t e;
    if (!reset) begin
      q.delete();
      m_ready = 1'b1;
      m_count = '0;
    end else begin
      acc    = in_valid && m_ready && !flush;
      pop    = (q.size() > 0) && wb_ready;
      e.data = mem_read ? mem_data : alu_result;
      e.rd   = rd;
      e.we   = reg_write && (rd != '0);
      if (pop) begin
        void'(q.pop_front());
        m_count++;
      end
      if (acc) q.push_back(e);
      if (flush) q.delete();
      m_ready = (q.size() < 2);
    end
  end

  always @(negedge clk) begin : compare
    if (reset) begin
      chk("in_ready", 64'(in_ready), 64'(m_ready));
      chk("wb_valid", 64'(wb_valid), 64'(q.size() > 0));
      chk("retire_count", 64'(retire_count), 64'(m_count));
      if (q.size() > 0) begin
        chk("wb_we", 64'(wb_we), 64'(q[0].we));
        chk("wb_rd", 64'(wb_rd), 64'(q[0].rd));
        chk("wb_data", 64'(wb_data), 64'(q[0].data));
      end else begin
        chk("wb_we_idle", 64'(wb_we), 64'(0));
      end
`ifdef FWD_BYPASS_EN
      begin : fwd_model
        logic          fv;
        logic [AW-1:0] fr;
        logic [DW-1:0] fd;
        fv = 1'b0;
        fr = '0;
        fd = '0;
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].we) begin
            fv = 1'b1;
            fr = q[i].rd;
            fd = q[i].data;
          end
        end
        chk("fwd_valid", 64'(fwd_valid), 64'(fv));
        chk("fwd_rd", 64'(fwd_rd), 64'(fr));
        chk("fwd_data", 64'(fwd_data), 64'(fd));
      end
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [AW-1:0] r);
    in_valid   = 1'b1;
    alu_result = d;
    mem_read   = 1'b0;
    reg_write  = 1'b1;
    rd         = r;
    step();
    in_valid   = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wb_valid"}, 64'(wb_valid), 64'(0));
    chk({tag, "_wb_we"}, 64'(wb_we), 64'(0));
    chk({tag, "_wb_rd"}, 64'(wb_rd), 64'(0));
    chk({tag, "_wb_data"}, 64'(wb_data), 64'(0));
    chk({tag, "_count"}, 64'(retire_count), 64'(0));
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    bit found;
    repeat (2) step();
    chk_reset_state("por");
    reset = 1'b1;
    step();

    // Simple ALU writeback
    wb_ready = 1'b1;
    push(32'h1234, 5'd5);
    chk("t2_valid", 64'(wb_valid), 64'(1));
    chk("t2_we", 64'(wb_we), 64'(1));
    chk("t2_rd", 64'(wb_rd), 64'(5));
    chk("t2_data", 64'(wb_data), 64'h1234);
    step();
    chk("t2_count", 64'(retire_count), 64'(1));

    // Load selects memory data
    in_valid = 1'b1; mem_read = 1'b1; mem_data = 32'hDEADBEEF; alu_result = 32'h40;
    reg_write = 1'b1; rd = 5'd7;
    step();
    in_valid = 1'b0; mem_read = 1'b0;
    chk("t3_data", 64'(wb_data), 64'hDEADBEEF);
    step();
    chk("t3_count", 64'(retire_count), 64'(2));

    // Write to x0 suppressed but still retires
    push(32'h55, 5'd0);
    chk("t4_valid", 64'(wb_valid), 64'(1));
    chk("t4_we", 64'(wb_we), 64'(0));
    step();
    chk("t4_count", 64'(retire_count), 64'(3));

    // Back-pressure: fill head + skid, then drain in order
    wb_ready = 1'b0;
    push(32'hAAAA0001, 5'd1);
    push(32'hBBBB0002, 5'd2);
    chk("t5_full_ready", 64'(in_ready), 64'(0));
    chk("t5_head_a", 64'(wb_data), 64'hAAAA0001);
    wb_ready = 1'b1;
    step();
    chk("t5_head_b", 64'(wb_data), 64'hBBBB0002);
    chk("t5_ready_back", 64'(in_ready), 64'(1));
    chk("t5_count_a", 64'(retire_count), 64'(4));
    step();
    chk("t5_count_b", 64'(retire_count), 64'(5));
    chk("t5_empty", 64'(wb_valid), 64'(0));

    // Flush with both slots full and a new input offered
    wb_ready = 1'b0;
    push(32'hC0C0, 5'd3);
    push(32'hD0D0, 5'd4);
    flush = 1'b1; in_valid = 1'b1; alu_result = 32'hE0E0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t6_valid", 64'(wb_valid), 64'(0));
    chk("t6_ready", 64'(in_ready), 64'(1));
    chk("t6_count", 64'(retire_count), 64'(5));
    step();
    chk("t6_dropped", 64'(wb_valid), 64'(0));

    // Reset asserted mid-cycle with both slots full
    push(32'h1111, 5'd9);
    push(32'h2222, 5'd10);
    #2 reset = 1'b0;
    #1;
    chk_reset_state("midrst");
    step();
    reset = 1'b1;
    step();

    // Stream until the counter wraps
    wb_ready = 1'b1;
    in_valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (m_count == 8'hFF && q.size() > 0) found = 1'b1;
      else begin
        alu_result = $urandom;
        rd = AW'($urandom_range(0, 31));
        step();
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL wrap_reach: count never reached ff within cycle budget");
    end else begin
      step();
      chk("wrap_count", 64'(retire_count), 64'(0));
    end

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 2000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      wb_ready   = ((i / 64) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      alu_result = $urandom;
      mem_data   = $urandom;
      mem_read   = ($urandom_range(0, 1) == 1);
      reg_write  = ($urandom_range(0, 3) != 0);
      rd         = AW'($urandom_range(0, 31));
      step();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
